// File: rtl/vector_core.sv
// vector_core: multi-cycle SIMD core (LOAD/STORE/ADD/MUL) over a
// vector register file, with valid/ready issue and req/ack memory port.
//
// Ports:
//   clk, reset        rising-edge clock; synchronous active-low reset
//   instr             {op[1:0], rd, rs1, rs2, addr}, MSB first
//   instr_valid       instruction offered by the sequencer
//   instr_ready       core can accept (IDLE only)
//   done              one-cycle pulse per retired instruction
//   busy              core is in any state other than IDLE
//   mem_req/mem_we    memory request (held until ack) / 1 = store
//   mem_addr          vector word address
//   mem_wdata         store data (rs1 captured at accept)
//   mem_rdata/mem_ack load data / request completion
//   rf_flat           register r at [r*LANES*EW +: LANES*EW]
//   instr_count       retired-instruction counter, wraps at 2^32
module vector_core #(
    parameter  int LANES   = 16,
    parameter  int EW      = 32,
    parameter  int NREGS   = 4,
    parameter  int AW      = 9,
    localparam int RW      = $clog2(NREGS),
    localparam int INSTR_W = 2 + 3*RW + AW,
    localparam int VW      = LANES*EW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INSTR_W-1:0]    instr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    output logic                  done,
    output logic                  busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [VW-1:0]         mem_wdata,
    input  logic [VW-1:0]         mem_rdata,
    input  logic                  mem_ack,
    output logic [NREGS*VW-1:0]   rf_flat,
    output logic [31:0]           instr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEM   = 2'd1,
        ARITH = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t state;
    state_t state_n;

    // Instruction field decode (incoming word).
    logic [1:0]    op_in;
    logic [RW-1:0] rd_in;
    logic [RW-1:0] rs1_in;
    logic [RW-1:0] rs2_in;
    logic [AW-1:0] addr_in;

    assign op_in   = instr[INSTR_W-1 -: 2];
    assign rd_in   = instr[AW+3*RW-1 -: RW];
    assign rs1_in  = instr[AW+2*RW-1 -: RW];
    assign rs2_in  = instr[AW+RW-1 -: RW];
    assign addr_in = instr[AW-1:0];

    // Latched instruction.
    logic [1:0]    op_q;
    logic [RW-1:0] rd_q;
    logic [RW-1:0] rs1_q;
    logic [RW-1:0] rs2_q;
    logic [AW-1:0] addr_q;
    logic [VW-1:0] wdata_q;

    // High-half destination; wraps naturally at RW bits.
    logic [RW-1:0] rd_hi;
    assign rd_hi = rd_q + RW'(1);

    logic [VW-1:0] rf [NREGS];

    logic [VW-1:0] res_lo;
    logic [VW-1:0] res_hi;
    logic [VW-1:0] lane_lo;
    logic [VW-1:0] lane_hi;

    logic          done_q;
    logic [31:0]   count_q;

    logic accept;
    logic retire;
    logic load_wr;

    assign accept  = (state == IDLE) && instr_valid;
    assign retire  = ((state == MEM) && mem_ack) || (state == WB);
    assign load_wr = (state == MEM) && mem_ack && !op_q[0];

    function automatic logic [2*EW-1:0] sx(input logic [EW-1:0] v);
        return {{EW{v[EW-1]}}, v};
    endfunction

    // Lane arithmetic. Operands are sign-extended to 2*EW so that the
    // low 2*EW bits of both the product and the sum are exact signed
    // results; op_q[0] selects MUL (11) over ADD (10).
    logic [2*EW-1:0] opa;
    logic [2*EW-1:0] opb;
    logic [2*EW-1:0] lres;

    always_comb begin
        lane_lo = '0;
        lane_hi = '0;
        opa     = '0;
        opb     = '0;
        lres    = '0;
        for (int l = 0; l < LANES; l++) begin
            opa  = sx(rf[rs1_q][l*EW +: EW]);
            opb  = sx(rf[rs2_q][l*EW +: EW]);
            lres = op_q[0] ? (opa * opb) : (opa + opb);
            lane_lo[l*EW +: EW] = lres[EW-1:0];
            lane_hi[l*EW +: EW] = lres[2*EW-1:EW];
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (instr_valid) begin
                    state_n = op_in[1] ? ARITH : MEM;
                end
            end
            MEM: begin
                if (mem_ack) begin
                    state_n = IDLE;
                end
            end
            ARITH: state_n = WB;
            WB:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath and register file.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            res_lo  <= '0;
            res_hi  <= '0;
            done_q  <= 1'b0;
            count_q <= '0;
            for (int r = 0; r < NREGS; r++) begin
                rf[r] <= '0;
            end
        end else begin
            done_q <= retire;
            if (retire) begin
                count_q <= count_q + 32'd1;
            end
            if (accept) begin
                op_q    <= op_in;
                rd_q    <= rd_in;
                rs1_q   <= rs1_in;
                rs2_q   <= rs2_in;
                addr_q  <= addr_in;
                wdata_q <= rf[rs1_in];
            end
            // Results are captured before WB writes, so any aliasing of
            // rd, rd+1, rs1 and rs2 reads the pre-instruction values.
            if (state == ARITH) begin
                res_lo <= lane_lo;
                res_hi <= lane_hi;
            end
            if (load_wr) begin
                rf[rd_q] <= mem_rdata;
            end
            if (state == WB) begin
                rf[rd_q]  <= res_lo;
                rf[rd_hi] <= res_hi;
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign rf_flat[g*VW +: VW] = rf[g];
    end

    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign mem_req     = (state == MEM);
    assign mem_we      = (state == MEM) && op_q[0];
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign done        = done_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_vector_core.sv
// Directed testbench for vector_core: reset, LOAD/STORE, MUL/ADD with
// high-half writeback, issue handshake with delayed ack, reset mid-MEM.
module tb_vector_core;

    localparam int LANES = 16;
    localparam int EW    = 32;
    localparam int NREGS = 4;
    localparam int AW    = 9;
    localparam int IW    = 17;
    localparam int VW    = LANES*EW;

    logic              clk = 1'b0;
    logic              reset;
    logic [IW-1:0]     instr;
    logic              instr_valid;
    logic              instr_ready;
    logic              done;
    logic              busy;
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [VW-1:0]     mem_wdata;
    logic [VW-1:0]     mem_rdata;
    logic              mem_ack;
    logic [NREGS*VW-1:0] rf_flat;
    logic [31:0]       instr_count;

    logic [VW-1:0] mem [0:511];
    logic          poke;
    logic [AW-1:0] poke_addr;
    logic [VW-1:0] poke_data;

    int npass = 0;
    int ntot  = 0;

    vector_core dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .done        (done),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .rf_flat     (rf_flat),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (poke) begin
            mem[poke_addr] <= poke_data;
        end else if (mem_req && mem_ack && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    function automatic logic [VW-1:0] fill(input logic [EW-1:0] v);
        logic [VW-1:0] x;
        for (int l = 0; l < LANES; l++) x[l*EW +: EW] = v;
        return x;
    endfunction

    function automatic logic [VW-1:0] seqv();
        logic [VW-1:0] x;
        for (int l = 0; l < LANES; l++) x[l*EW +: EW] = EW'(l + 1);
        return x;
    endfunction

    function automatic logic [VW-1:0] rreg(input int r);
        return rf_flat[r*VW +: VW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chkv(input string tag, input logic [VW-1:0] obs,
                        input logic [VW-1:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %b want %b", tag, obs, exp);
    endtask

    task automatic poke_w(input logic [AW-1:0] a, input logic [VW-1:0] d);
        poke      = 1'b1;
        poke_addr = a;
        poke_data = d;
        step();
        poke      = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2,
                         input logic [AW-1:0] a);
        instr       = {op, rd, rs1, rs2, a};
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    task automatic load(input logic [1:0] rd, input logic [AW-1:0] a);
        issue(2'b00, rd, 2'd0, 2'd0, a);
        step();
    endtask

    initial begin
        reset       = 1'b0;
        instr       = 17'h1ABCD;
        instr_valid = 1'b1;
        mem_ack     = 1'b1;
        poke        = 1'b0;
        poke_addr   = '0;
        poke_data   = '0;

        // Reset with garbage on the issue port.
        step();
        step();
        for (int r = 0; r < NREGS; r++)
            chkv($sformatf("rst_r%0d", r), rreg(r), '0);
        chkw("rst_cnt", instr_count, 32'd0);
        chkb("rst_req", mem_req, 1'b0);
        chkb("rst_done", done, 1'b0);
        chkb("rst_ready", instr_ready, 1'b1);
        chkb("rst_busy", busy, 1'b0);
        instr_valid = 1'b0;

        poke_w(9'd5,  seqv());
        poke_w(9'd10, fill(32'h7FFFFFFF));
        poke_w(9'd11, fill(32'd2));
        poke_w(9'd12, fill(32'hFFFFFFFB));
        poke_w(9'd13, fill(32'd3));
        poke_w(9'd14, fill(32'd1));
        reset = 1'b1;

        // LOAD r0,5 then STORE r0 -> 9, ack tied high.
        issue(2'b00, 2'd0, 2'd0, 2'd0, 9'd5);
        chkb("ld_req", mem_req, 1'b1);
        chkb("ld_we", mem_we, 1'b0);
        chkw("ld_addr", 32'(mem_addr), 32'd5);
        chkb("ld_ready", instr_ready, 1'b0);
        chkb("ld_busy", busy, 1'b1);
        step();
        chkb("ld_done", done, 1'b1);
        chkb("ld_reqlow", mem_req, 1'b0);
        chkv("ld_r0", rreg(0), seqv());
        issue(2'b01, 2'd0, 2'd0, 2'd0, 9'd9);
        chkb("st_we", mem_we, 1'b1);
        chkv("st_wdata", mem_wdata, seqv());
        step();
        chkb("st_done", done, 1'b1);
        chkv("st_mem9", mem[9], seqv());
        chkw("st_cnt", instr_count, 32'd2);

        // MUL r3 = r3 * r1, high half wraps into r0.
        load(2'd3, 9'd10);
        load(2'd1, 9'd11);
        issue(2'b11, 2'd3, 2'd3, 2'd1, 9'd0);
        chkb("mul_busy", busy, 1'b1);
        chkb("mul_req", mem_req, 1'b0);
        step();
        chkb("mul_nodone", done, 1'b0);
        step();
        chkb("mul_done", done, 1'b1);
        chkv("mul_r3", rreg(3), fill(32'hFFFFFFFE));
        chkv("mul_r0", rreg(0), fill(32'h00000000));
        chkv("mul_r1", rreg(1), fill(32'd2));
        chkw("mul_cnt", instr_count, 32'd5);

        // ADD -5 + 3.
        load(2'd0, 9'd12);
        load(2'd1, 9'd13);
        issue(2'b10, 2'd2, 2'd0, 2'd1, 9'd0);
        step();
        step();
        chkb("add1_done", done, 1'b1);
        chkv("add1_r2", rreg(2), fill(32'hFFFFFFFE));
        chkv("add1_r3", rreg(3), fill(32'hFFFFFFFF));

        // ADD 0x7FFFFFFF + 1.
        load(2'd0, 9'd10);
        load(2'd1, 9'd14);
        issue(2'b10, 2'd2, 2'd0, 2'd1, 9'd0);
        step();
        step();
        chkv("add2_r2", rreg(2), fill(32'h80000000));
        chkv("add2_r3", rreg(3), fill(32'h00000000));

        // Same add into rd=3: high half wraps onto rs1 (r0).
        issue(2'b10, 2'd3, 2'd0, 2'd1, 9'd0);
        step();
        step();
        chkv("add3_r3", rreg(3), fill(32'h80000000));
        chkv("add3_r0", rreg(0), fill(32'h00000000));
        chkw("add3_cnt", instr_count, 32'd12);

        // Handshake: valid held high, ack delayed.
        mem_ack     = 1'b0;
        instr       = {2'b00, 2'd2, 2'd0, 2'd0, 9'd5};
        instr_valid = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            chkb($sformatf("hs_ready%0d", i), instr_ready, 1'b0);
            chkb($sformatf("hs_busy%0d", i), busy, 1'b1);
            chkb($sformatf("hs_req%0d", i), mem_req, 1'b1);
            chkw($sformatf("hs_addr%0d", i), 32'(mem_addr), 32'd5);
            chkb($sformatf("hs_done%0d", i), done, 1'b0);
            if (i < 3) step();
        end
        mem_ack = 1'b1;
        step();
        chkb("hs_ret1", done, 1'b1);
        chkv("hs_r2", rreg(2), seqv());
        chkw("hs_cnt1", instr_count, 32'd13);
        step();
        chkb("hs_busy2", busy, 1'b1);
        chkb("hs_nodone", done, 1'b0);
        step();
        chkb("hs_ret2", done, 1'b1);
        chkw("hs_cnt2", instr_count, 32'd14);
        instr_valid = 1'b0;
        step();
        chkb("hs_idle_done", done, 1'b0);
        chkb("hs_idle_busy", busy, 1'b0);
        chkw("hs_cnt3", instr_count, 32'd14);

        // Reset while a load is waiting for ack.
        mem_ack = 1'b0;
        issue(2'b00, 2'd1, 2'd0, 2'd0, 9'd5);
        chkb("mr_req", mem_req, 1'b1);
        reset = 1'b0;
        step();
        chkb("mr_reqlow", mem_req, 1'b0);
        chkb("mr_busy", busy, 1'b0);
        chkb("mr_ready", instr_ready, 1'b1);
        chkb("mr_done", done, 1'b0);
        chkw("mr_cnt", instr_count, 32'd0);
        chkw("mr_addr", 32'(mem_addr), 32'd0);
        for (int r = 0; r < NREGS; r++)
            chkv($sformatf("mr_r%0d", r), rreg(r), '0);
        reset = 1'b1;
        step();
        chkb("mr_nodone", done, 1'b0);
        chkv("mr_r1", rreg(1), '0);
        chkb("mr_busy2", busy, 1'b0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
